video_timing: RTL and testbench



---
 rtl/video_timing.sv | 97 +++++++++
 tb/tb_video_timing.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator: pixel position, syncs, active flag and frame-start pulse.
// Optional frame counter on o_frame when VIDEO_TIMING_FRAME_CNT_EN is defined.
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_active,
  output logic        o_frame_start,
  output logic [15:0] o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        wrap;

  // Next position is decoded first so every registered output describes the same pixel.
  always_comb begin
    x_next = o_x;
    y_next = o_y;
    wrap   = 1'b0;
    if (i_pix_en) begin
      if (o_x == H_LAST) begin
        x_next = 16'd0;
        if (o_y == V_LAST) begin
          y_next = 16'd0;
          wrap   = 1'b1;
        end else begin
          y_next = o_y + 16'd1;
        end
      end else begin
        x_next = o_x + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_x           <= H_LAST;
      o_y           <= V_LAST;
      o_h_sync      <= ~H_POL;
      o_v_sync      <= ~V_POL;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_x           <= x_next;
      o_y           <= y_next;
      o_h_sync      <= ((x_next >= HS_START) && (x_next < HS_END)) ? H_POL : ~H_POL;
      o_v_sync      <= ((y_next >= VS_START) && (y_next < VS_END)) ? V_POL : ~V_POL;
      o_active      <= (x_next < H_ACT_END) && (y_next < V_ACT_END);
      o_frame_start <= wrap;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt <= 16'd0;
    end else if (wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign o_frame = frame_cnt;
`else
  assign o_frame = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench: a small-raster DUT and a default-parameter DUT share stimulus;
// expected outputs come from a behavioural position model pushed into a queue.
module tb_video_timing;

  // Small raster: 15 x 10 pixels, 150 clocks per frame at full rate.
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam bit S_HPOL = 1'b1, S_VPOL = 1'b0;

  localparam int D_HT = 800, D_VT = 525;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic [15:0] s_x, s_y, s_frame, d_x, d_y, d_frame;
  logic        s_hs, s_vs, s_act, s_fs, d_hs, d_vs, d_act, d_fs;

  always #5 clk = ~clk;

  video_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(S_HPOL), .V_POL(S_VPOL)
  ) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_x(s_x), .o_y(s_y), .o_h_sync(s_hs), .o_v_sync(s_vs),
    .o_active(s_act), .o_frame_start(s_fs), .o_frame(s_frame)
  );

  video_timing dut_dflt (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_x(d_x), .o_y(d_y), .o_h_sync(d_hs), .o_v_sync(d_vs),
    .o_active(d_act), .o_frame_start(d_fs), .o_frame(d_frame)
  );

  typedef struct packed {
    logic [15:0] x, y;
    logic        hs, vs, act, fs;
    logic [15:0] frame;
    logic [15:0] dx, dy;
    logic        dhs, dvs, dact, dfs;
    logic [15:0] dframe;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  int sx, sy, dx, dy;
  bit sfs, dfs;
  logic [15:0] sfr, dfr;

  task automatic adv(input int ht, input int vt, input bit r, input bit en,
                     inout int x, inout int y, output bit fs);
    fs = 1'b0;
    if (!r) begin
      x = ht - 1;
      y = vt - 1;
    end else if (en) begin
      if (x == ht - 1) begin
        x = 0;
        if (y == vt - 1) begin
          y = 0;
          fs = 1'b1;
        end else begin
          y = y + 1;
        end
      end else begin
        x = x + 1;
      end
    end
  endtask

  function automatic logic sync_of(input int v, input int lo, input int w, input bit pol);
    return (v >= lo && v < lo + w) ? pol : !pol;
  endfunction

  function automatic logic [15:0] frame_of(input bit r, input bit fs, input logic [15:0] cur);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    if (!r) return 16'd0;
    return fs ? cur + 16'd1 : cur;
`else
    return 16'd0;
`endif
  endfunction

  // Drive one clock of stimulus away from the active edge and queue the expected result.
  task automatic step(input bit r, input bit en);
    exp_t n;
    @(negedge clk);
    rst_n  = r;
    pix_en = en;
    adv(S_HT, S_VT, r, en, sx, sy, sfs);
    adv(D_HT, D_VT, r, en, dx, dy, dfs);
    sfr = frame_of(r, sfs, sfr);
    dfr = frame_of(r, dfs, dfr);
    n.x      = 16'(sx);
    n.y      = 16'(sy);
    n.hs     = sync_of(sx, S_HA + S_HF, S_HS, S_HPOL);
    n.vs     = sync_of(sy, S_VA + S_VF, S_VS, S_VPOL);
    n.act    = (sx < S_HA) && (sy < S_VA);
    n.fs     = sfs;
    n.frame  = sfr;
    n.dx     = 16'(dx);
    n.dy     = 16'(dy);
    n.dhs    = sync_of(dx, 656, 96, 1'b0);
    n.dvs    = sync_of(dy, 490, 2, 1'b0);
    n.dact   = (dx < 640) && (dy < 480);
    n.dfs    = dfs;
    n.dframe = dfr;
    sbq.push_back(n);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if ({s_x, s_y, s_hs, s_vs, s_act, s_fs, s_frame} !==
          {e.x, e.y, e.hs, e.vs, e.act, e.fs, e.frame}) begin
        bad++;
        $display("FAIL small t=%0t got x=%0d y=%0d hs=%b vs=%b act=%b fs=%b fr=%0d want x=%0d y=%0d hs=%b vs=%b act=%b fs=%b fr=%0d",
                 $time, s_x, s_y, s_hs, s_vs, s_act, s_fs, s_frame,
                 e.x, e.y, e.hs, e.vs, e.act, e.fs, e.frame);
      end
      total++;
      if ({d_x, d_y, d_hs, d_vs, d_act, d_fs, d_frame} !==
          {e.dx, e.dy, e.dhs, e.dvs, e.dact, e.dfs, e.dframe}) begin
        bad++;
        $display("FAIL dflt t=%0t got x=%0d y=%0d hs=%b vs=%b act=%b fs=%b fr=%0d want x=%0d y=%0d hs=%b vs=%b act=%b fs=%b fr=%0d",
                 $time, d_x, d_y, d_hs, d_vs, d_act, d_fs, d_frame,
                 e.dx, e.dy, e.dhs, e.dvs, e.dact, e.dfs, e.dframe);
      end
    end
  end

  initial begin
    logic [7:0] pat;
    int cnt_fs;
    sx = 0; sy = 0; dx = 0; dy = 0;
    sfs = 1'b0; dfs = 1'b0;
    sfr = 16'd0; dfr = 16'd0;

    // Reset held 3 clocks with enable high: reset must win.
    repeat (3) step(1'b0, 1'b1);

    // Full rate: first clock wraps to (0,0), then three more frames.
    for (int i = 0; i < 3 * S_HT * S_VT + 10; i++) step(1'b1, 1'b1);

    // One enabled clock in four.
    for (int i = 0; i < 4 * S_HT * S_VT + 100; i++) step(1'b1, (i % 4) == 0);

    // Irregular enable pattern.
    pat = 8'b1011_0010;
    for (int i = 0; i < 120; i++) step(1'b1, pat[i % 8]);

    // Carry the default raster past its sync region and into the next line.
    for (int i = 0; i < 250; i++) step(1'b1, 1'b1);

    // Mid-frame reset on the small raster at (5,3).
    for (int i = 0; i < 200 && !(sx == 5 && sy == 3); i++) step(1'b1, 1'b1);
    total++;
    if (!(sx == 5 && sy == 3)) begin
      bad++;
      $display("FAIL midframe_reach got x=%0d y=%0d want x=5 y=3", sx, sy);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * S_HT * S_VT + 20; i++) step(1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end

    // Independent sanity: frame-start seen on the very first enabled edge after reset.
    cnt_fs = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    @(posedge clk);
    #2;
    if (s_fs) cnt_fs++;
    total++;
    if (cnt_fs != 1 || s_x != 16'd0 || s_y != 16'd0) begin
      bad++;
      $display("FAIL first_wrap got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", s_fs, s_x, s_y);
    end
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
